// File: rtl/ctrig_pkg.sv
// Shared types and default widths for the trigger sequencer.
package ctrig_pkg;

   localparam int unsigned CTRIG_CNT_W   = 16;
   localparam int unsigned CTRIG_BURST_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      ACTIVE,
      GAP,
      FINISH
   } ctrig_state_t;

endpackage

// File: rtl/trigger_sequencer_if.sv
// Host-side command/config/status bundle of the trigger sequencer.
interface trigger_sequencer_if #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned BURST_W = 8
);
   logic               start;
   logic               abort;
   logic [CNT_W-1:0]   cfg_delay;
   logic [CNT_W-1:0]   cfg_width;
   logic [CNT_W-1:0]   cfg_gap;
   logic [BURST_W-1:0] cfg_count;
   logic               trigger;
   logic               busy;
   logic               done;
   logic [BURST_W-1:0] burst_idx;

   modport master (
      output start, abort, cfg_delay, cfg_width, cfg_gap, cfg_count,
      input  trigger, busy, done, burst_idx
   );

   modport slave (
      input  start, abort, cfg_delay, cfg_width, cfg_gap, cfg_count,
      output trigger, busy, done, burst_idx
   );
endinterface

// File: rtl/ctrig_down_counter.sv
// Loadable down-counter that parks at zero; shared by the delay, width and gap phases.
module ctrig_down_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   assign zero = (count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !zero) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/trigger_sequencer.sv
// Programmable delay/width/gap trigger burst generator in the fastclk domain.
module trigger_sequencer
   import ctrig_pkg::*;
#(
   parameter int unsigned CNT_W   = CTRIG_CNT_W,
   parameter int unsigned BURST_W = CTRIG_BURST_W
) (
   input logic                fastclk,
   input logic                reset,
   trigger_sequencer_if.slave bus
);

   ctrig_state_t       state, state_nxt;
   logic               accept;
   logic               idx_inc;
   logic               cnt_load;
   logic [CNT_W-1:0]   cnt_val;
   logic               cnt_en;
   logic               cnt_zero;
   logic [CNT_W-1:0]   w_m1_in, g_m1_in;
   logic [CNT_W-1:0]   w_m1_sh, g_m1_sh;
   logic [BURST_W-1:0] last_idx_sh;
   logic [BURST_W-1:0] idx_q;
   logic               trig_q, busy_q, done_q;

   // Zero width/gap behave as one cycle, so reload values saturate at 0.
   assign w_m1_in = (bus.cfg_width == '0) ? '0 : bus.cfg_width - CNT_W'(1);
   assign g_m1_in = (bus.cfg_gap   == '0) ? '0 : bus.cfg_gap   - CNT_W'(1);
   assign cnt_en  = (state == DELAY) || (state == ACTIVE) || (state == GAP);

   ctrig_down_counter #(.W(CNT_W)) u_cnt (
      .clk      (fastclk),
      .rst      (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .count    (),
      .zero     (cnt_zero)
   );

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      idx_inc   = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      unique case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               accept = 1'b1;
               if (bus.cfg_count == '0) begin
                  state_nxt = FINISH;
               end else if (bus.cfg_delay != '0) begin
                  state_nxt = DELAY;
                  cnt_load  = 1'b1;
                  cnt_val   = bus.cfg_delay - CNT_W'(1);
               end else begin
                  state_nxt = ACTIVE;
                  cnt_load  = 1'b1;
                  cnt_val   = w_m1_in;
               end
            end
         end
         DELAY: begin
            if (cnt_zero) begin
               state_nxt = ACTIVE;
               cnt_load  = 1'b1;
               cnt_val   = w_m1_sh;
            end
         end
         ACTIVE: begin
            if (cnt_zero) begin
               if (idx_q == last_idx_sh) begin
                  state_nxt = FINISH;
               end else begin
                  state_nxt = GAP;
                  cnt_load  = 1'b1;
                  cnt_val   = g_m1_sh;
               end
            end
         end
         GAP: begin
            if (cnt_zero) begin
               state_nxt = ACTIVE;
               cnt_load  = 1'b1;
               cnt_val   = w_m1_sh;
               idx_inc   = 1'b1;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.abort && state != IDLE) begin
         state_nxt = IDLE;
         cnt_load  = 1'b0;
         idx_inc   = 1'b0;
      end
   end

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         w_m1_sh     <= '0;
         g_m1_sh     <= '0;
         last_idx_sh <= '0;
      end else if (accept) begin
         w_m1_sh     <= w_m1_in;
         g_m1_sh     <= g_m1_in;
         last_idx_sh <= bus.cfg_count - BURST_W'(1);
      end
   end

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         idx_q <= '0;
      end else if (accept) begin
         idx_q <= '0;
      end else if (idx_inc) begin
         idx_q <= idx_q + BURST_W'(1);
      end
   end

   // Trigger/done follow the state one edge later; busy rises on the accepting edge.
   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         trig_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         trig_q <= (state == ACTIVE) && !bus.abort;
         done_q <= (state == FINISH) && !bus.abort;
         busy_q <= accept || (cnt_en && !bus.abort);
      end
   end

   assign bus.trigger   = trig_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.burst_idx = idx_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed self-checking bench for trigger_sequencer.
module tb_trigger_sequencer;

   logic fastclk = 1'b0;
   logic reset   = 1'b1;
   int   tests   = 0;
   int   fails   = 0;

   trigger_sequencer_if #(.CNT_W(16), .BURST_W(8)) bus ();

   trigger_sequencer #(.CNT_W(16), .BURST_W(8)) dut (
      .fastclk (fastclk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 fastclk = ~fastclk;

   task automatic step();
      @(posedge fastclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string pfx, input int e, input bit t, input bit b, input bit d);
      chk($sformatf("%s_trig_e%0d", pfx, e), 32'(bus.trigger), 32'(t));
      chk($sformatf("%s_busy_e%0d", pfx, e), 32'(bus.busy), 32'(b));
      chk($sformatf("%s_done_e%0d", pfx, e), 32'(bus.done), 32'(d));
   endtask

   task automatic set_cfg(input int d, input int w, input int g, input int n);
      bus.cfg_delay = 16'(d);
      bus.cfg_width = 16'(w);
      bus.cfg_gap   = 16'(g);
      bus.cfg_count = 8'(n);
   endtask

   // Nominal D=3 W=4 G=2 N=2; with hazard set, a start and new width are offered mid-burst.
   task automatic run_nominal(input string pfx, input bit hazard);
      set_cfg(3, 4, 2, 2);
      bus.start = 1'b1;
      for (int e = 0; e <= 15; e++) begin
         step();
         chk_outs(pfx, e, (e >= 4 && e <= 7) || (e >= 10 && e <= 13), e <= 13, e == 14);
         if (e == 6)  chk({pfx, "_idx0"}, 32'(bus.burst_idx), 32'd0);
         if (e == 12) chk({pfx, "_idx1"}, 32'(bus.burst_idx), 32'd1);
         bus.start = 1'b0;
         if (hazard && e == 5) begin
            bus.start = 1'b1;
            set_cfg(0, 7, 5, 5);
         end
      end
      chk({pfx, "_idx_hold"}, 32'(bus.burst_idx), 32'd1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_cfg(0, 0, 0, 0);

      // Reset held: outputs at their reset values.
      step();
      step();
      chk_outs("rst_hold", 0, 1'b0, 1'b0, 1'b0);
      chk("rst_hold_idx", 32'(bus.burst_idx), 32'd0);
      #3 reset = 1'b0;
      step();
      chk_outs("idle", 0, 1'b0, 1'b0, 1'b0);

      run_nominal("nom", 1'b0);
      run_nominal("haz", 1'b1);

      // All-zero timing fields, three pulses.
      set_cfg(0, 0, 0, 3);
      bus.start = 1'b1;
      for (int e = 0; e <= 8; e++) begin
         step();
         chk_outs("zero", e, (e == 1) || (e == 3) || (e == 5), e <= 5, e == 6);
         if (e == 5) chk("zero_idx2", 32'(bus.burst_idx), 32'd2);
         bus.start = 1'b0;
      end

      // Empty sequence.
      set_cfg(2, 3, 1, 0);
      bus.start = 1'b1;
      for (int e = 0; e <= 3; e++) begin
         step();
         chk_outs("empty", e, 1'b0, e == 0, e == 1);
         bus.start = 1'b0;
      end

      // Abort during pulse 1 of D=0 W=10 G=2 N=4.
      set_cfg(0, 10, 2, 4);
      bus.start = 1'b1;
      for (int e = 0; e <= 25; e++) begin
         step();
         chk_outs("abort", e, (e >= 1 && e <= 10) || e == 13, e <= 13, 1'b0);
         if (e == 13) chk("abort_idx_pre", 32'(bus.burst_idx), 32'd1);
         bus.start = 1'b0;
         bus.abort = (e == 13);
      end
      chk("abort_idx_held", 32'(bus.burst_idx), 32'd1);

      // Start and abort together in IDLE.
      set_cfg(0, 2, 1, 2);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      for (int e = 0; e <= 5; e++) begin
         step();
         chk_outs("startabort", e, 1'b0, 1'b0, 1'b0);
         bus.start = 1'b0;
         bus.abort = 1'b0;
      end

      // Asynchronous reset mid-ACTIVE, then idle until a new start.
      set_cfg(0, 10, 2, 4);
      bus.start = 1'b1;
      for (int e = 0; e <= 13; e++) begin
         step();
         bus.start = 1'b0;
      end
      chk("arst_pre_trig", 32'(bus.trigger), 32'd1);
      chk("arst_pre_idx", 32'(bus.burst_idx), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk_outs("arst", 0, 1'b0, 1'b0, 1'b0);
      chk("arst_idx", 32'(bus.burst_idx), 32'd0);
      step();
      #2 reset = 1'b0;
      for (int e = 0; e <= 5; e++) begin
         step();
         chk_outs("post_rst", e, 1'b0, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Programmable burst generator that drives the `trigger` input of the ClocknTrigger / ClocknTriggerDC gated-clock blocks.
- On a `start` command it waits a configured delay, then emits N trigger windows of configured width separated by a configured gap.
- Reports busy and done status to the host.
- Runs entirely in the `fastclk` domain. Its `trigger` output connects directly to the gated-clock block's `trigger` port.

Parameters:
- CNT_W, 16, width of the delay, width and gap counters (in fastclk cycles).
- BURST_W, 8, width of the burst-count field and of `burst_idx`.

Ports:
- fastclk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a sequence; sampled on a fastclk rising edge; acted on only in IDLE.
- abort  input  1  terminate any sequence immediately.
- cfg_delay  input  CNT_W  cycles from start to first trigger rise.
- cfg_width  input  CNT_W  trigger high time per pulse; 0 is treated as 1.
- cfg_gap  input  CNT_W  low time between pulses; 0 is treated as 1.
- cfg_count  input  BURST_W  number of pulses; 0 means an empty sequence.
- trigger  output  1  registered trigger to the gated-clock block.
- busy  output  1  high while a sequence is in progress.
- done  output  1  single-cycle pulse when a sequence completes normally.
- burst_idx  output  BURST_W  index of the current or last pulse, 0-based.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - trigger=0, busy=0, done=0, burst_idx=0.
  - All counters clear.
  - Outputs are held at these values for as long as reset is high.
- All outputs are registered; there are no combinational paths from input to output.
- Config latching:
  - cfg_* are captured into shadow registers on the edge where start is accepted.
  - Later cfg_* changes have no effect until the next sequence.
- FSM states: IDLE, DELAY, ACTIVE, GAP, FINISH.
- IDLE:
  - start=1 and abort=0 → latch cfg, burst_idx=0, busy=1.
  - Next state is DELAY if cfg_delay>0, else ACTIVE.
  - If cfg_count=0, go to FINISH instead.
- DELAY: counts cfg_delay cycles, then → ACTIVE.
- ACTIVE:
  - trigger=1 for exactly max(cfg_width,1) cycles.
  - At the end: if burst_idx = count-1 → FINISH; else → GAP.
- GAP:
  - trigger=0 for max(cfg_gap,1) cycles, then → ACTIVE.
  - burst_idx increments on the GAP→ACTIVE transition.
- FINISH: lasts one cycle with done=1, busy=0, then → IDLE.
- Timing, with start sampled at edge k:
  - trigger first rises at edge k+1+cfg_delay.
  - Pulse p rises at edge k+1+D+p·(W+G).
  - done is high during the cycle after edge k+1+D+N·W+(N-1)·G; busy falls on that same edge.
  - An empty sequence (count=0) gives busy high for 1 cycle, then done for 1 cycle, with no trigger.
- abort:
  - From any non-IDLE state → IDLE on the next edge.
  - trigger=0, busy=0, done is NOT asserted, burst_idx holds its value.
  - abort and start in the same cycle in IDLE: abort wins; start is ignored.
- start while busy, or during FINISH, is ignored; it is not queued.
- burst_idx does not wrap; cfg_count ≤ 2^BURST_W−1 bounds it.
- Counters are down-counters loaded with value−1. Terminal count is 0. There is no arithmetic overflow.

Decomposition:
- Package `ctrig_pkg`:
  - FSM state enum (IDLE, DELAY, ACTIVE, GAP, FINISH).
  - Default CNT_W and BURST_W localparams.
- Sub-module `ctrig_down_counter` (param W):
  - Ports: load, load_val, en, count, zero.
  - Instantiated once and shared across the DELAY, ACTIVE and GAP phases.
- FSM and output registers live in `trigger_sequencer`.

Test Plan:
- Reset: assert reset mid-ACTIVE at a non-edge time → trigger/busy/done/burst_idx go to 0 immediately (asynchronously); after release, the FSM idles until the next start.
- Nominal burst: D=3, W=4, G=2, N=2, start at edge 0 → trigger high for edges 4–7 and 10–13; done for one cycle after edge 14; busy high for edges 1–13; burst_idx reads 0 then 1.
- Zero fields: D=0, W=0, G=0, N=3 → trigger rises at edge 1; three 1-cycle pulses separated by 1-cycle gaps; done after the third pulse.
- Empty sequence: N=0 → busy for 1 cycle, done for 1 cycle, trigger never asserted.
- Abort mid-burst: D=0, W=10, N=4, abort during pulse 1 → trigger low and busy low on the next edge; no done; burst_idx=1 is held.
- Start/config hazards:
  - Start while busy → ignored; the burst is unchanged.
  - cfg_width changed mid-sequence → the pulse width is unchanged.
  - Start and abort together in IDLE → no sequence starts.
